fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-domain pointer/flag controller of the dual-clock FIFO; pairs with the write-side pointer logic.
//  Brings the write-domain Gray write pointer across the boundary with a 2-flop synchroniser.
//  Advances binary and Gray read pointers on accepted reads, drives the RAM read address.
//  Generates empty, almost_empty and occupancy for the consumer; its Gray pointer feeds the write-side full check.
// PARAMETERS
//  ADDR_W           3   RAM address width; depth = 2**ADDR_W (8); pointers are ADDR_W+1 bits (4)
//  ALMOST_EMPTY_TH  1   almost_empty asserts when rd_count <= this value
// PORTS
//  rclk            in   1         read-domain clock, all flops rising-edge
//  rrst_n          in   1         asynchronous, active-low reset for every flop in this block
//  rd_enable_fifo  in   1         read request from consumer
//  g_wr_ptr        in   ADDR_W+1  Gray write pointer, write clock domain (unsynchronised)
//  empty           out  1         no readable entry
//  almost_empty    out  1         rd_count <= ALMOST_EMPTY_TH
//  rd_fire         out  1         read accepted this cycle (rd_enable_fifo & ~empty)
//  rd_addr         out  ADDR_W    RAM read address = b_rd_ptr[ADDR_W-1:0]
//  rd_count        out  ADDR_W+1  occupancy seen by read side, 0..2**ADDR_W
//  b_rd_ptr        out  ADDR_W+1  binary read pointer
//  g_rd_ptr        out  ADDR_W+1  Gray read pointer, to write-domain synchroniser
//  g_wr_ptr_sync   out  ADDR_W+1  synchronised Gray write pointer (2nd sync flop)
//  underflow       out  1         read-while-empty indication (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, release on rclk): b_rd_ptr=0, g_rd_ptr=0, both sync stages=0, underflow=0;
//    hence empty=1, almost_empty=1, rd_count=0, rd_fire=0, rd_addr=0. Reset mid-operation clears all at once.
//  - Synchroniser: sync1 <= g_wr_ptr; g_wr_ptr_sync <= sync1. A write-side change is visible after 2 rclk edges.
//  - empty = (g_rd_ptr == g_wr_ptr_sync), combinational; no registered flag.
//  - On rd_fire: b_rd_ptr <= b_rd_ptr+1; g_rd_ptr <= (b_rd_ptr+1) ^ ((b_rd_ptr+1)>>1), i.e. Gray of the NEW
//    binary value, same edge; g_rd_ptr never lags b_rd_ptr.
//  - rd_enable_fifo while empty: pointers hold, no address change.
//  - Pointers wrap modulo 2**(ADDR_W+1) (binary 15->0, Gray 1000->0000 at default); MSB is wrap bit.
//  - rd_count = gray2bin(g_wr_ptr_sync) - b_rd_ptr, modulo 2**(ADDR_W+1); gray2bin is XOR prefix from MSB.
//    Combinational; max value 2**ADDR_W (full). Stale by sync latency, never overstates readable data.
//  - almost_empty combinational from rd_count; empty implies almost_empty.
//  - Read data: RAM sampled at rd_addr by the consumer; rd_addr is the entry returned by the current rd_fire.
//  - Simultaneous write-pointer change and read: independent; read acceptance uses current g_wr_ptr_sync only.
//  - Only one Gray bit of g_rd_ptr changes per accepted read (required for safe crossing).
// CONFIGURATION
//  FIFO_RD_UNDERFLOW_EN defined: underflow <= rd_enable_fifo & empty each rclk edge (1-cycle pulse,
//    registered, one cycle after the offending request); cleared by rrst_n.
//  FIFO_RD_UNDERFLOW_EN undefined: underflow tied to 1'b0, no flop instantiated.
// TESTING
//  1 Reset: rrst_n=0 any state -> empty=1, almost_empty=1, rd_count=0, b_rd_ptr=0, g_rd_ptr=0, underflow=0.
//  2 Sync latency: g_wr_ptr 0000->0001 -> edge1 empty=1; after edge2 g_wr_ptr_sync=0001, empty=0, rd_count=1,
//    almost_empty=1 (TH=1); g_wr_ptr=0011 -> rd_count=2, almost_empty=0 two edges later.
//  3 Drain full: g_wr_ptr=1100 (8 entries), rd_enable_fifo=1 for 8 cycles -> g_rd_ptr 0001,0011,0010,0110,0111,
//    0101,0100,1100; rd_addr 0..7; rd_count 8->0; empty=1 and rd_fire=0 on cycle 9.
//  4 Wrap: stream 16 writes/reads -> b_rd_ptr 1111->0000, g_rd_ptr 1000->0000, rd_addr 7->0; one Gray bit per step.
//  5 Underflow: empty=1, rd_enable_fifo=1 one cycle -> pointers unchanged; with FIFO_RD_UNDERFLOW_EN underflow=1
//    for exactly one cycle after the edge; without it underflow stays 0.
//  6 Reset mid-drain: b_rd_ptr=5, g_wr_ptr_sync=1100, assert rrst_n=0 -> b_rd_ptr, g_rd_ptr, sync flops=0
//    immediately; after release with g_wr_ptr=0000 empty=1, rd_count=0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain pointer and flag controller of a dual-clock FIFO.
// Optional feature macro: FIFO_RD_UNDERFLOW_EN (registered read-while-empty pulse).
module fifo_read_ctrl #(
    parameter int ADDR_W          = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rd_enable_fifo,
    input  logic [ADDR_W:0]   g_wr_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic              rd_fire,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_count,
    output logic [ADDR_W:0]   b_rd_ptr,
    output logic [ADDR_W:0]   g_rd_ptr,
    output logic [ADDR_W:0]   g_wr_ptr_sync,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AE_TH   = (ADDR_W+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    logic [ADDR_W:0] sync1_r;
    logic [ADDR_W:0] g_wr_sync_r;
    logic [ADDR_W:0] b_rd_ptr_r;
    logic [ADDR_W:0] g_rd_ptr_r;
    logic [ADDR_W:0] b_rd_next_s;
    logic [ADDR_W:0] rd_count_s;
    logic            empty_s;
    logic            rd_fire_s;

    // Occupancy, empty and read-acceptance decode from the synchronised write pointer
    always_comb begin
        rd_count_s  = gray2bin(g_wr_sync_r) - b_rd_ptr_r;
        empty_s     = (g_rd_ptr_r == g_wr_sync_r);
        b_rd_next_s = b_rd_ptr_r + PTR_ONE;
        if (rd_enable_fifo && !empty_s) begin
            rd_fire_s = 1'b1;
        end else begin
            rd_fire_s = 1'b0;
        end
    end

    // Two-flop synchroniser for the write-domain Gray pointer
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync1_r     <= '0;
            g_wr_sync_r <= '0;
        end else begin
            sync1_r     <= g_wr_ptr;
            g_wr_sync_r <= sync1_r;
        end
    end

    // Binary and Gray read pointers advance together so the Gray copy never lags
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rd_ptr_r <= '0;
            g_rd_ptr_r <= '0;
        end else if (rd_fire_s) begin
            b_rd_ptr_r <= b_rd_next_s;
            g_rd_ptr_r <= bin2gray(b_rd_next_s);
        end else begin
            b_rd_ptr_r <= b_rd_ptr_r;
            g_rd_ptr_r <= g_rd_ptr_r;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic underflow_r;

    // One-cycle pulse flagging a request made while nothing was readable
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= rd_enable_fifo & empty_s;
        end
    end

    assign underflow = underflow_r;
`else
    assign underflow = 1'b0;
`endif

    assign empty         = empty_s;
    assign almost_empty  = (rd_count_s <= AE_TH);
    assign rd_fire       = rd_fire_s;
    assign rd_addr       = b_rd_ptr_r[ADDR_W-1:0];
    assign rd_count      = rd_count_s;
    assign b_rd_ptr      = b_rd_ptr_r;
    assign g_rd_ptr      = g_rd_ptr_r;
    assign g_wr_ptr_sync = g_wr_sync_r;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl against a pointer-count reference model.
module tb_fifo_read_ctrl;

    localparam int AW = 3;
    localparam int PM = 16;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rd_enable_fifo = 1'b0;
    logic [AW:0]   g_wr_ptr = '0;
    logic          empty, almost_empty, rd_fire, underflow;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_count, b_rd_ptr, g_rd_ptr, g_wr_ptr_sync;

    int n_tests = 0;
    int n_fail  = 0;

    // model: write count, what each sync stage holds (binary), read count
    int m_wp = 0, m_s1 = 0, m_s2 = 0, m_rp = 0;
    logic m_uf = 1'b0;

    fifo_read_ctrl dut (
        .rclk(rclk), .rrst_n(rrst_n), .rd_enable_fifo(rd_enable_fifo),
        .g_wr_ptr(g_wr_ptr), .empty(empty), .almost_empty(almost_empty),
        .rd_fire(rd_fire), .rd_addr(rd_addr), .rd_count(rd_count),
        .b_rd_ptr(b_rd_ptr), .g_rd_ptr(g_rd_ptr), .g_wr_ptr_sync(g_wr_ptr_sync),
        .underflow(underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input int b);
        int v;
        v = b % PM;
        return 4'(v ^ (v / 2));
    endfunction

    function automatic int m_cnt();
        return (m_s2 - m_rp + PM) % PM;
    endfunction

    function automatic int popc(input logic [AW:0] v);
        int c = 0;
        for (int i = 0; i <= AW; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic drive(input logic ren);
        rd_enable_fifo = ren;
        g_wr_ptr = gray(m_wp);
        #1;
    endtask

    task automatic tick();
        logic fire, emp;
        emp  = (m_cnt() == 0);
        fire = rd_enable_fifo && !emp;
        @(posedge rclk);
`ifdef FIFO_RD_UNDERFLOW_EN
        m_uf = rd_enable_fifo && emp;
`else
        m_uf = 1'b0;
`endif
        if (fire) m_rp = (m_rp + 1) % PM;
        m_s2 = m_s1;
        m_s1 = m_wp;
        @(negedge rclk);
    endtask

    task automatic model_reset();
        m_wp = 0; m_s1 = 0; m_s2 = 0; m_rp = 0; m_uf = 1'b0;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        model_reset();
        drive(1'b1);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        n_tests++; if (rd_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rd_count); end
        n_tests++; if (b_rd_ptr !== 4'd0 || g_rd_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptrs: got b=%0d g=%0d want 0", b_rd_ptr, g_rd_ptr); end
        n_tests++; if (rd_fire !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_fire_uf: got fire=%b uf=%b want 0", rd_fire, underflow); end
        @(negedge rclk);
        rrst_n = 1'b1;
        drive(1'b0);
    endtask

    task automatic test_sync_latency();
        m_wp = 1;
        drive(1'b0);
        tick();
        drive(1'b0);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sync_edge1_empty: got %b want 1", empty); end
        tick();
        drive(1'b0);
        n_tests++; if (g_wr_ptr_sync !== 4'b0001) begin n_fail++; $display("FAIL sync_edge2_ptr: got %b want 0001", g_wr_ptr_sync); end
        n_tests++; if (empty !== 1'b0 || rd_count !== 4'd1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL sync_edge2_flags: got e=%b c=%0d ae=%b want 0 1 1", empty, rd_count, almost_empty); end
        m_wp = 2;
        drive(1'b0);
        tick();
        drive(1'b0);
        n_tests++; if (rd_count !== 4'd1) begin n_fail++; $display("FAIL sync2_edge1_count: got %0d want 1", rd_count); end
        tick();
        drive(1'b0);
        n_tests++; if (rd_count !== 4'd2 || almost_empty !== 1'b0) begin n_fail++; $display("FAIL sync2_edge2: got c=%0d ae=%b want 2 0", rd_count, almost_empty); end
    endtask

    task automatic test_drain_full();
        logic [AW:0] gtab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        m_wp = 8;
        drive(1'b0); tick();
        drive(1'b0); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            n_tests++; if (rd_addr !== 3'(i) || rd_count !== 4'(8 - i) || rd_fire !== 1'b1) begin n_fail++; $display("FAIL drain_%0d: got addr=%0d cnt=%0d fire=%b want %0d %0d 1", i, rd_addr, rd_count, rd_fire, i, 8 - i); end
            tick();
            n_tests++; if (g_rd_ptr !== gtab[i]) begin n_fail++; $display("FAIL drain_gray_%0d: got %b want %b", i, g_rd_ptr, gtab[i]); end
        end
        drive(1'b1);
        n_tests++; if (empty !== 1'b1 || rd_fire !== 1'b0 || rd_count !== 4'd0) begin n_fail++; $display("FAIL drain_end: got e=%b fire=%b c=%0d want 1 0 0", empty, rd_fire, rd_count); end
        tick();
    endtask

    task automatic test_random_wrap();
        logic [AW:0] g_prev, b_prev;
        logic        fire_exp;
        int          wraps = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(3) != 0 && (m_wp - m_rp + PM) % PM < 8) m_wp = (m_wp + 1) % PM;
            drive(1'($urandom_range(3) != 0));
            fire_exp = rd_enable_fifo && (m_cnt() != 0);
            n_tests++; if (rd_count !== 4'(m_cnt())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, rd_count, m_cnt()); end
            n_tests++; if (empty !== (m_cnt() == 0) || almost_empty !== (m_cnt() <= 1)) begin n_fail++; $display("FAIL rnd_flags@%0d: got e=%b ae=%b cnt=%0d", cyc, empty, almost_empty, m_cnt()); end
            n_tests++; if (rd_fire !== fire_exp) begin n_fail++; $display("FAIL rnd_fire@%0d: got %b want %b", cyc, rd_fire, fire_exp); end
            n_tests++; if (b_rd_ptr !== 4'(m_rp) || rd_addr !== 3'(m_rp % 8) || g_rd_ptr !== gray(m_rp)) begin n_fail++; $display("FAIL rnd_ptr@%0d: got b=%0d a=%0d g=%b want b=%0d", cyc, b_rd_ptr, rd_addr, g_rd_ptr, m_rp); end
            n_tests++; if (g_wr_ptr_sync !== gray(m_s2) || underflow !== m_uf) begin n_fail++; $display("FAIL rnd_sync_uf@%0d: got s=%b uf=%b want s=%b uf=%b", cyc, g_wr_ptr_sync, underflow, gray(m_s2), m_uf); end
            g_prev = g_rd_ptr;
            b_prev = b_rd_ptr;
            tick();
            if (b_prev == 4'd15 && b_rd_ptr == 4'd0) wraps++;
            n_tests++; if (popc(g_rd_ptr ^ g_prev) !== (fire_exp ? 1 : 0)) begin n_fail++; $display("FAIL rnd_gray_step@%0d: got %b->%b fire=%b", cyc, g_prev, g_rd_ptr, fire_exp); end
        end
        n_tests++; if (wraps < 1) begin n_fail++; $display("FAIL rnd_wrap: got %0d wraps want >=1", wraps); end
    endtask

    task automatic test_underflow();
        logic [AW:0] b0, g0;
        for (int i = 0; i < 40 && m_cnt() != 0; i++) begin
            drive(1'b1);
            tick();
        end
        drive(1'b1);
        n_tests++; if (empty !== 1'b1 || rd_fire !== 1'b0) begin n_fail++; $display("FAIL uf_empty: got e=%b fire=%b want 1 0", empty, rd_fire); end
        b0 = b_rd_ptr; g0 = g_rd_ptr;
        tick();
        drive(1'b0);
        n_tests++; if (b_rd_ptr !== b0 || g_rd_ptr !== g0) begin n_fail++; $display("FAIL uf_hold: got b=%0d g=%b want b=%0d g=%b", b_rd_ptr, g_rd_ptr, b0, g0); end
`ifdef FIFO_RD_UNDERFLOW_EN
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse: got %b want 1", underflow); end
`else
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_off: got %b want 0", underflow); end
`endif
        tick();
        drive(1'b0);
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_reset_mid_drain();
        test_reset();
        m_wp = 8;
        drive(1'b0); tick();
        drive(1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            tick();
        end
        drive(1'b0);
        n_tests++; if (b_rd_ptr !== 4'd5 || g_wr_ptr_sync !== 4'b1100) begin n_fail++; $display("FAIL mid_setup: got b=%0d s=%b want 5 1100", b_rd_ptr, g_wr_ptr_sync); end
        #1 rrst_n = 1'b0;
        #1;
        n_tests++; if (b_rd_ptr !== 4'd0 || g_rd_ptr !== 4'd0 || g_wr_ptr_sync !== 4'd0) begin n_fail++; $display("FAIL mid_async: got b=%0d g=%b s=%b want 0", b_rd_ptr, g_rd_ptr, g_wr_ptr_sync); end
        model_reset();
        drive(1'b0);
        @(negedge rclk);
        rrst_n = 1'b1;
        drive(1'b0); tick();
        drive(1'b0); tick();
        drive(1'b0);
        n_tests++; if (empty !== 1'b1 || rd_count !== 4'd0) begin n_fail++; $display("FAIL mid_release: got e=%b c=%0d want 1 0", empty, rd_count); end
    endtask

    initial begin
        @(negedge rclk);
        test_reset();
        test_sync_latency();
        test_drain_full();
        test_random_wrap();
        test_underflow();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
